debounce_multi: RTL and testbench

Multi-channel, parametrised debouncer for button and switch banks. Each channel filters a synchronous 1-bit input through its own saturating stability counter. Each channel also emits one-cycle rise and fall strobes when its debounced level changes, plus an aggregate "any change" strobe. The block sits between the input synchronisers (or the optional internal synchroniser) and the control logic that consumes key events.

---
 rtl/debounce_multi_pkg.sv | 19 +
 rtl/debounce_channel.sv | 67 ++++++
 rtl/debounce_multi.sv | 80 ++++++++
 tb/tb_debounce_multi.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// ============================================================================
//  Module      : debounce_multi_pkg
//  Description : Shared constants and width helper for the debouncer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_multi_pkg;

  localparam int SYNC_STAGES = 2;

  // Counter only has to reach MAX_COUNT-1, so clog2(MAX_COUNT) bits suffice.
  function automatic int counter_bits(input int max_count);
    return $clog2(max_count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
//  Module      : debounce_channel
//  Description : One debounce channel: saturating stability counter, level
//                register and registered rise/fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int   MAX_COUNT   = 16,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic i_nrst,
  input  logic i_sample,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                    COUNTER_BITS = counter_bits(MAX_COUNT);
  localparam logic [COUNTER_BITS-1:0] C_LAST     = COUNTER_BITS'(MAX_COUNT - 1);

  logic [COUNTER_BITS-1:0] count_q, count_d;
  logic                    level_q, level_d;
  logic                    rise_q,  rise_d;
  logic                    fall_q,  fall_d;

  always_comb begin
    count_d = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_sample != level_q) begin
      if (count_q == C_LAST) begin
        level_d = i_sample;
        rise_d  = i_sample;
        fall_d  = ~i_sample;
      end else begin
        count_d = count_q + COUNTER_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      count_q <= '0;
      level_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
//  Module      : debounce_multi
//  Description : Multi-channel debouncer with per-channel rise/fall strobes
//                and an aggregate change strobe. Define DEBOUNCE_SYNC_EN to
//                put a 2-flop synchroniser in front of every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   MAX_COUNT   = 16,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic                clock,
  input  logic                i_nrst,
  input  logic [CHANNELS-1:0] i_in,
  output logic [CHANNELS-1:0] o_out,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_changed
);

  logic [CHANNELS-1:0] sample;
  logic                changed_q, changed_d;

`ifdef DEBOUNCE_SYNC_EN
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_in};
  end

  always_ff @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q <= {(SYNC_STAGES * CHANNELS){RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];
`else
  assign sample = i_in;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
    debounce_channel #(
      .MAX_COUNT   (MAX_COUNT),
      .RESET_VALUE (RESET_VALUE)
    ) u_channel (
      .clock    (clock),
      .i_nrst   (i_nrst),
      .i_sample (sample[gi]),
      .o_level  (o_out[gi]),
      .o_rise   (o_rise[gi]),
      .o_fall   (o_fall[gi])
    );
  end

  // One pulse per accept edge, however many channels accepted together.
  always_comb begin
    changed_d = |(o_rise | o_fall);
  end

  always_ff @(posedge clock or negedge i_nrst) begin
    if (!i_nrst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign o_changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Self-checking bench for debounce_multi (CHANNELS=4,
//                MAX_COUNT=4, RESET_VALUE=0), default build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

  localparam int CHANNELS  = 4;
  localparam int MAX_COUNT = 4;

  typedef struct {
    logic       nrst;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } vec_t;

  logic                clock = 1'b0;
  logic                i_nrst;
  logic [CHANNELS-1:0] i_in;
  logic [CHANNELS-1:0] o_out;
  logic [CHANNELS-1:0] o_rise;
  logic [CHANNELS-1:0] o_fall;
  logic                o_changed;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  debounce_multi #(
    .CHANNELS    (CHANNELS),
    .MAX_COUNT   (MAX_COUNT),
    .RESET_VALUE (1'b0)
  ) dut (
    .clock     (clock),
    .i_nrst    (i_nrst),
    .i_in      (i_in),
    .o_out     (o_out),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_changed (o_changed)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int row, input logic [3:0] got,
                       input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic n, input logic [3:0] in, input logic [3:0] out,
                     input logic [3:0] rise, input logic [3:0] fall, input logic chg,
                     input int reps = 1);
    vec_t v;
    v.nrst = n; v.in = in; v.out = out; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  initial begin
    int cycles;
    i_nrst = 1'b0;
    i_in   = 4'h0;

    // Reset with inputs high, then release: accept on 4th edge.
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 2);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3);
    add(1, 4'hF, 4'hF, 4'hF, 4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 1);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
    // All channels fall.
    add(1, 4'h0, 4'hF, 4'h0, 4'h0, 0, 3);
    add(1, 4'h0, 4'h0, 4'h0, 4'hF, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    // Glitch on ch0 for 3 samples is rejected.
    add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 3);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2);
    // Bounce on ch1 then settle high.
    add(1, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h2, 4'h0, 4'h0, 4'h0, 0, 3);
    add(1, 4'h2, 4'h2, 4'h2, 4'h0, 0);
    add(1, 4'h2, 4'h2, 4'h0, 4'h0, 1);
    // ch2 up, then ch2 falls.
    add(1, 4'h6, 4'h2, 4'h0, 4'h0, 0, 3);
    add(1, 4'h6, 4'h6, 4'h4, 4'h0, 0);
    add(1, 4'h6, 4'h6, 4'h0, 4'h0, 1);
    add(1, 4'h2, 4'h6, 4'h0, 4'h0, 0, 3);
    add(1, 4'h2, 4'h2, 4'h0, 4'h4, 0);
    add(1, 4'h2, 4'h2, 4'h0, 4'h0, 1);
    // ch3 up, then simultaneous ch0 rise / ch3 fall.
    add(1, 4'hA, 4'h2, 4'h0, 4'h0, 0, 3);
    add(1, 4'hA, 4'hA, 4'h8, 4'h0, 0);
    add(1, 4'hA, 4'hA, 4'h0, 4'h0, 1);
    add(1, 4'h3, 4'hA, 4'h0, 4'h0, 0, 3);
    add(1, 4'h3, 4'h3, 4'h1, 4'h8, 0);
    add(1, 4'h3, 4'h3, 4'h0, 4'h0, 1);
    // Clear all, then reset in the middle of a ch0 count.
    add(1, 4'h0, 4'h3, 4'h0, 4'h0, 0, 3);
    add(1, 4'h0, 4'h0, 4'h0, 4'h3, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 3);
    add(0, 4'h1, 4'h0, 4'h0, 4'h0, 0);
    add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 3);
    add(1, 4'h1, 4'h1, 4'h1, 4'h0, 0);
    add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    add(1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      i_nrst = vecs[i].nrst;
      i_in   = vecs[i].in;
      @(posedge clock);
      #1;
      check("out",     i, o_out,  vecs[i].out);
      check("rise",    i, o_rise, vecs[i].rise);
      check("fall",    i, o_fall, vecs[i].fall);
      check("changed", i, {3'b0, o_changed}, {3'b0, vecs[i].chg});
    end

    // Reset acts without a clock edge.
    i_nrst = 1'b0;
    #2;
    check("async_rst_out", 100, o_out, 4'h0);
    @(posedge clock);
    #1;
    i_nrst = 1'b1;
    i_in   = 4'hF;

    // Wait for the accept with a bounded budget, then check pulse shape.
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (o_rise == 4'h0 && cycles < 10);
    check("accept_latency", 101, 4'(cycles), 4'(MAX_COUNT));
    check("accept_rise",    101, o_rise, 4'hF);
    check("accept_out",     101, o_out,  4'hF);
    @(posedge clock);
    #1;
    check("rise_one_cycle", 102, o_rise, 4'h0);
    check("changed_after",  102, {3'b0, o_changed}, 4'h1);
    @(posedge clock);
    #1;
    check("changed_one_cycle", 103, {3'b0, o_changed}, 4'h0);
    check("held_no_fall",      103, o_fall, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
